// File: rtl/rf_arb_pkg.sv
// Shared constants and requester encoding for the register-file write arbiter.
package rf_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        REQ_WB = 1'b0,
        REQ_MD = 1'b1
    } req_sel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for multi-cycle mul/div results: RAW stall and WAW issue gating.
module rf_scoreboard #(
    parameter int ADDR_W = rf_arb_pkg::ADDR_W,
    parameter int NREGS  = rf_arb_pkg::NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_issue_rd,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_rd,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rt,
    output logic              o_issue_ready,
    output logic              o_stall
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;
    logic             w_set_en;

    assign o_issue_ready = ~r_pending[i_issue_rd];
    assign w_set_en      = i_issue && o_issue_ready;

    // Clear is applied before set so a same-edge set of the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) begin
            w_pending_nxt[i_clr_rd] = 1'b0;
        end
        if (w_set_en) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_stall = ((i_rs != '0) && r_pending[i_rs]) ||
                     ((i_rt != '0) && r_pending[i_rt]);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates WB and mul/div writes onto one registered register-file write port.
// Define RF_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed WB priority.
module rf_write_arbiter #(
    parameter int DATA_W = rf_arb_pkg::DATA_W,
    parameter int ADDR_W = rf_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_gnt,
    input  logic              md_req,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_gnt,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_rd,
    output logic              md_issue_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              stall,
    output logic              reg_write,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data
);

    import rf_arb_pkg::*;

    req_sel_e          w_sel;
    logic              w_any_gnt;
    logic [ADDR_W-1:0] w_gnt_rd;
    logic [DATA_W-1:0] w_gnt_data;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_wdata;

`ifdef RF_ARB_ROUND_ROBIN_EN
    req_sel_e r_prio;
    req_sel_e w_prio_nxt;

    // Pointer names the side that wins the next contested cycle.
    always_comb begin
        w_sel      = REQ_WB;
        w_prio_nxt = r_prio;
        if (wb_req && md_req) begin
            w_sel      = r_prio;
            w_prio_nxt = (r_prio == REQ_WB) ? REQ_MD : REQ_WB;
        end else if (md_req) begin
            w_sel = REQ_MD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= REQ_WB;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end
`else
    always_comb begin
        w_sel = REQ_WB;
        if (md_req && !wb_req) begin
            w_sel = REQ_MD;
        end
    end
`endif

    assign wb_gnt     = !rst && wb_req && (w_sel == REQ_WB);
    assign md_gnt     = !rst && md_req && (w_sel == REQ_MD);
    assign w_any_gnt  = wb_gnt || md_gnt;
    assign w_gnt_rd   = (w_sel == REQ_MD) ? md_rd   : wb_rd;
    assign w_gnt_data = (w_sel == REQ_MD) ? md_data : wb_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wdata     <= '0;
        end else if (w_any_gnt) begin
            r_reg_write <= (w_gnt_rd != '0);
            r_rd        <= w_gnt_rd;
            r_wdata     <= w_gnt_data;
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign reg_write  = r_reg_write;
    assign rd         = r_rd;
    assign write_data = r_wdata;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (1 << ADDR_W)
    ) u_scoreboard (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_issue       (md_issue),
        .i_issue_rd    (md_issue_rd),
        .i_clr_en      (md_gnt),
        .i_clr_rd      (md_rd),
        .i_rs          (rs),
        .i_rt          (rt),
        .o_issue_ready (md_issue_ready),
        .o_stall       (stall)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req, md_req, md_issue;
    logic [4:0]  wb_rd, md_rd, md_issue_rd, rs, rt;
    logic [31:0] wb_data, md_data;
    logic        wb_gnt, md_gnt, md_issue_ready, stall, reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .md_req(md_req), .md_rd(md_rd), .md_data(md_data), .md_gnt(md_gnt),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd), .md_issue_ready(md_issue_ready),
        .rs(rs), .rt(rt), .stall(stall),
        .reg_write(reg_write), .rd(rd), .write_data(write_data)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: architectural view of pending writes and the write port.
    bit [31:0]   m_pend;
    bit          m_rw;
    bit [4:0]    m_rd;
    bit [31:0]   m_wd;
    bit          m_known;
    bit          m_valid = 1'b0;
    int unsigned m_contested;
    bit          g_wb, g_md;
    bit          a_wb, a_md;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; wb_req = 1'b0; md_req = 1'b0; md_issue = 1'b0;
        wb_rd = '0; md_rd = '0; md_issue_rd = '0; rs = '0; rt = '0;
        wb_data = '0; md_data = '0;
    endtask

    task automatic cycle();
        bit ewb, emd, eready, estall;
        @(negedge clk);
        ewb = 1'b0;
        emd = 1'b0;
        if (!rst) begin
            if (wb_req && md_req) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
                if (m_contested % 2 == 0) ewb = 1'b1; else emd = 1'b1;
`else
                ewb = 1'b1;
`endif
            end else begin
                ewb = wb_req;
                emd = md_req;
            end
        end
        a_wb = wb_gnt;
        a_md = md_gnt;
        chk("wb_gnt", wb_gnt, ewb);
        chk("md_gnt", md_gnt, emd);
        if (m_valid) begin
            eready = !m_pend[md_issue_rd];
            estall = (rs != 0 && m_pend[rs]) || (rt != 0 && m_pend[rt]);
            chk("md_issue_ready", md_issue_ready, eready);
            chk("stall", stall, estall);
            chk("reg_write", reg_write, m_rw);
            if (m_known) begin
                chk("rd", rd, m_rd);
                chk("write_data", write_data, m_wd);
            end
        end else begin
            eready = 1'b0;
        end
        if (rst) begin
            m_pend = '0; m_rw = 0; m_rd = '0; m_wd = '0;
            m_known = 1'b1; m_valid = 1'b1; m_contested = 0;
        end else if (m_valid) begin
            if (wb_req && md_req) m_contested++;
            if (ewb || emd) begin
                m_rd    = ewb ? wb_rd : md_rd;
                m_wd    = ewb ? wb_data : md_data;
                m_rw    = (m_rd != 0);
                m_known = m_rw;
            end else begin
                m_rw = 1'b0;
            end
            if (emd) m_pend[md_rd] = 1'b0;
            if (md_issue && eready && md_issue_rd != 0) m_pend[md_issue_rd] = 1'b1;
        end
        g_wb = ewb;
        g_md = emd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_reg_write", reg_write, 1'b0);
        chk("reset_rd_data", {rd, write_data}, 37'd0);

        // Basic WB write.
        wb_req = 1'b1; wb_rd = 5'd2; wb_data = 32'd5;
        cycle();
        wb_req = 1'b0;
        chk("wb_basic_gnt", a_wb, 1'b1);
        chk("wb_basic_port", {reg_write, rd, write_data}, {1'b1, 5'd2, 32'd5});
        cycle();

        // RAW stall on a pending mul/div result.
        md_issue = 1'b1; md_issue_rd = 5'd3; rs = 5'd3;
        cycle();
        md_issue = 1'b0;
        cycle();
        chk("raw_stall_set", stall, 1'b1);
        md_req = 1'b1; md_rd = 5'd3; md_data = 32'hAA;
        cycle();
        md_req = 1'b0;
        chk("raw_md_port", {reg_write, rd, write_data}, {1'b1, 5'd3, 32'hAA});
        chk("raw_stall_clr", stall, 1'b0);
        cycle();

        // Contention from a fresh reset.
        do_reset();
        wb_req = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        md_req = 1'b1; md_rd = 5'd5; md_data = 32'h55;
        for (int k = 0; k < 4; k++) begin
            cycle();
`ifdef RF_ARB_ROUND_ROBIN_EN
            chk("contend_pattern", {a_wb, a_md}, (k % 2 == 0) ? 2'b10 : 2'b01);
`else
            chk("contend_pattern", {a_wb, a_md}, 2'b10);
`endif
        end
        idle();
        cycle();

        // WAW gating: reissue of a still-pending destination.
        md_issue = 1'b1; md_issue_rd = 5'd6;
        cycle();
        chk("waw_ready_pending", md_issue_ready, 1'b0);
        md_req = 1'b1; md_rd = 5'd6; md_data = 32'h66;
        cycle();
        md_req = 1'b0;
        cycle();
        md_issue = 1'b0; rs = 5'd6;
        cycle();
        chk("waw_repending", stall, 1'b1);
        idle();

        // Write to r0 is consumed silently.
        wb_req = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        cycle();
        wb_req = 1'b0;
        chk("r0_gnt", a_wb, 1'b1);
        chk("r0_no_write", reg_write, 1'b0);
        cycle();

        // Reset clears the scoreboard.
        md_issue = 1'b1; md_issue_rd = 5'd7;
        cycle();
        md_issue = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0; rs = 5'd7; md_issue_rd = 5'd7;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_ready", md_issue_ready, 1'b1);
        chk("rst_reg_write", reg_write, 1'b0);
        cycle();

        // Write granted in the cycle reset asserts is dropped.
        idle();
        wb_req = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_drop", reg_write, 1'b0);
        cycle();
        wb_req = 1'b0;
        cycle();

        // Randomized traffic; requesters hold until granted.
        idle();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!wb_req && ($urandom % 3 == 0)) begin
                wb_req = 1'b1; wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            end
            if (!md_req && ($urandom % 3 == 0)) begin
                md_req = 1'b1; md_rd = 5'($urandom_range(0, 7)); md_data = $urandom;
            end
            md_issue    = ($urandom % 3 == 0);
            md_issue_rd = 5'($urandom_range(0, 7));
            rs          = 5'($urandom_range(0, 7));
            rt          = 5'($urandom_range(0, 7));
            cycle();
            if (g_wb) wb_req = 1'b0;
            if (g_md) md_req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
